led_breath_pwm: RTL and testbench

//  Multi-channel LED "breathing" driver: per-channel brightness levels ramp up/down (triangle) or
//  up-and-wrap (sawtooth) and are converted to PWM outputs by one shared period counter.

---
 rtl/led_breath_pwm.sv | 123 ++++++++++++
 tb/tb_led_breath_pwm.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/led_breath_pwm.sv
// Multi-channel LED breathing driver: triangle/sawtooth level ramps feeding a shared PWM period counter.
// pwm_out and period_tick lag the counter by one cycle; level_out is the level register itself. No backpressure.
module led_breath_pwm #(
    parameter int NCH        = 8,
    parameter int WIDTH      = 8,
    parameter int PRESC_W    = 16,
    parameter int PHASE_STEP = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [PRESC_W-1:0]   step_div,
    output logic [NCH-1:0]       pwm_out,
    output logic [NCH*WIDTH-1:0] level_out,
    output logic                 period_tick
);

    localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    typedef enum logic {UP, DOWN} dir_t;

    function automatic logic [WIDTH-1:0] start_lvl(input int ch);
        int v;
        v = ch * PHASE_STEP;
        if (v > int'(MAXV)) v = int'(MAXV);
        return v[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0]   pcnt_q, pcnt_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0]   level_q [NCH];
    logic [WIDTH-1:0]   level_d [NCH];
    dir_t               dir_q   [NCH];
    dir_t               dir_d   [NCH];
    logic [NCH-1:0]     pwm_q, pwm_d;
    logic               tick_q, tick_d;
    logic               boundary;
    logic               step;

    always_comb begin
        pcnt_d   = pcnt_q;
        presc_d  = presc_q;
        boundary = en && (pcnt_q == MAXV - ONE);
        step     = 1'b0;
        tick_d   = boundary;
        pwm_d    = '0;

        if (en) pcnt_d = boundary ? '0 : pcnt_q + ONE;

        // >= so that lowering step_div below the running count steps at the next boundary
        if (boundary) begin
            if (presc_q >= step_div) begin
                presc_d = '0;
                step    = 1'b1;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end

        for (int i = 0; i < NCH; i++) begin
            level_d[i] = level_q[i];
            dir_d[i]   = dir_q[i];
            pwm_d[i]   = en && (pcnt_q < level_q[i]);
            if (step) begin
                if (mode) begin
                    dir_d[i]   = UP;
                    level_d[i] = (level_q[i] == MAXV) ? '0 : level_q[i] + ONE;
                end else begin
                    case (dir_q[i])
                        UP: begin
                            if (level_q[i] == MAXV) begin
                                level_d[i] = MAXV - ONE;
                                dir_d[i]   = DOWN;
                            end else begin
                                level_d[i] = level_q[i] + ONE;
                            end
                        end
                        default: begin
                            if (level_q[i] == '0) begin
                                level_d[i] = ONE;
                                dir_d[i]   = UP;
                            end else begin
                                level_d[i] = level_q[i] - ONE;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q  <= '0;
            presc_q <= '0;
            pwm_q   <= '0;
            tick_q  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                level_q[i] <= start_lvl(i);
                dir_q[i]   <= UP;
            end
        end else begin
            pcnt_q  <= pcnt_d;
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
            tick_q  <= tick_d;
            for (int i = 0; i < NCH; i++) begin
                level_q[i] <= level_d[i];
                dir_q[i]   <= dir_d[i];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_lvl
        assign level_out[g*WIDTH +: WIDTH] = level_q[g];
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;

endmodule

// File: tb/tb_led_breath_pwm.sv
// Bench for led_breath_pwm: a phase-based reference model queues the expected outputs of every
// clock edge; a separate monitor pops and compares them against the DUT one step after the edge.
module tb_led_breath_pwm;

    localparam int NCH        = 2;
    localparam int WIDTH      = 4;
    localparam int PRESC_W    = 4;
    localparam int PHASE_STEP = 8;
    localparam int MAXV       = 15;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en  = 1'b0;
    logic               mode = 1'b0;
    logic [PRESC_W-1:0] step_div = '0;
    logic [NCH-1:0]       pwm_out;
    logic [NCH*WIDTH-1:0] level_out;
    logic                 period_tick;

    led_breath_pwm #(
        .NCH(NCH), .WIDTH(WIDTH), .PRESC_W(PRESC_W), .PHASE_STEP(PHASE_STEP)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .step_div(step_div),
        .pwm_out(pwm_out), .level_out(level_out), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0]       pwm;
        logic                 tick;
        logic [NCH*WIDTH-1:0] lvl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: a triangle is a phase 0..2*MAXV-1 folded into a level; sawtooth keeps phase == level.
    int m_pc;
    int m_ps;
    int m_ph [NCH];
    bit m_live = 1'b0;

    function automatic int lev(input int ph);
        return (ph <= MAXV) ? ph : 2 * MAXV - ph;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    initial begin : model
        exp_t e;
        forever begin
            @(posedge clk);
            e = '0;
            if (rst) begin
                m_pc = 0;
                m_ps = 0;
                for (int c = 0; c < NCH; c++)
                    m_ph[c] = (c * PHASE_STEP > MAXV) ? MAXV : c * PHASE_STEP;
                m_live = 1'b1;
            end else if (m_live && en) begin
                for (int c = 0; c < NCH; c++) e.pwm[c] = (m_pc < lev(m_ph[c]));
                e.tick = (m_pc == MAXV - 1);
                if (m_pc == MAXV - 1) begin
                    if (m_ps >= int'(step_div)) begin
                        m_ps = 0;
                        for (int c = 0; c < NCH; c++) begin
                            if (mode) m_ph[c] = (lev(m_ph[c]) + 1) % (MAXV + 1);
                            else      m_ph[c] = (m_ph[c] + 1) % (2 * MAXV);
                        end
                    end else begin
                        m_ps++;
                    end
                end
                m_pc = (m_pc + 1) % MAXV;
            end
            if (m_live) begin
                for (int c = 0; c < NCH; c++) e.lvl[c*WIDTH +: WIDTH] = WIDTH'(lev(m_ph[c]));
                exp_q.push_back(e);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pwm_out",     8'(pwm_out),     8'(e.pwm));
                chk("period_tick", 8'(period_tick), 8'(e.tick));
                chk("level_out",   8'(level_out),   8'(e.lvl));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_level"}, 8'(level_out), 8'h80);
        chk({name, "_pwm"},   8'(pwm_out),   8'h00);
        chk({name, "_tick"},  8'(period_tick), 8'h00);
    endtask

    initial begin : stim
        int n;
        rst = 1'b1; en = 1'b1; mode = 1'b0; step_div = '0;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("reset");

        // full triangle cycle of ch0 plus margin, one step per period
        cyc(2 * MAXV * MAXV + 40);

        // slower prescaler, then lower it while the count sits at 2
        step_div = 4'd2;
        cyc(150);
        step_div = 4'd3;
        n = 0;
        while (m_ps != 2 && n < 300) begin cyc(1); n++; end
        checks++;
        if (m_ps != 2) begin errors++; $display("FAIL presc_wait: got %0d expected 2", m_ps); end
        step_div = 4'd0;
        cyc(60);

        // sawtooth through the wrap, then back to triangle at level 3
        mode = 1'b1;
        cyc(MAXV * 20);
        n = 0;
        while (lev(m_ph[0]) != 3 && n < 400) begin cyc(1); n++; end
        mode = 1'b0;
        cyc(100);

        // freeze mid-period
        cyc(7);
        en = 1'b0;
        cyc(20);
        en = 1'b1;
        cyc(60);

        // reset while ch0 is descending and en is low
        n = 0;
        while (m_ph[0] <= MAXV && n < 600) begin cyc(1); n++; end
        checks++;
        if (m_ph[0] <= MAXV) begin errors++; $display("FAIL down_wait: got phase %0d", m_ph[0]); end
        en = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk_reset_state("midramp_reset");
        en = 1'b1;
        cyc(40);

        // randomized run
        for (int i = 0; i < 3000; i++) begin
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 199) == 0) mode = ~mode;
            if ($urandom_range(0, 299) == 0) step_div = 4'($urandom_range(0, 3));
            cyc(1);
        end
        rst = 1'b0;
        cyc(3);

        checks++;
        if (exp_q.size() > 1) begin
            errors++;
            $display("FAIL queue_drain: got %0d expected <=1", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
